// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the BCD adder sequencing controller
package calc_pkg;

  localparam int BCD_MAX         = 9;
  localparam int NUM_DIGITS_DFLT = 4;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    SUMMING,
    RESULT,
    RELOAD
  } calc_state_t;

endpackage

// File: rtl/calc_ctrl_if.sv
// rtl/calc_ctrl_if.sv - button inputs, command strobes and display scan of calc_ctrl
interface calc_ctrl_if #(
  parameter int NUM_DIGITS = calc_pkg::NUM_DIGITS_DFLT
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  push;
  logic                  guardar;
  logic                  finalizar;
  logic [3:0]            entrada;
  logic                  sum_done;
  logic                  dig_shift;
  logic [3:0]            dig_value;
  logic                  op_save;
  logic                  sum_start;
  logic                  clr_entry;
  logic                  show_result;
  logic [SEL_W-1:0]      digit_sel;
  logic [NUM_DIGITS-1:0] an;
  logic                  err;

  modport master (
    output push, guardar, finalizar, entrada, sum_done,
    input  dig_shift, dig_value, op_save, sum_start, clr_entry,
    input  show_result, digit_sel, an, err
  );

  modport slave (
    input  push, guardar, finalizar, entrada, sum_done,
    output dig_shift, dig_value, op_save, sum_start, clr_entry,
    output show_result, digit_sel, an, err
  );

endinterface

// File: rtl/calc_edge.sv
// rtl/calc_edge.sv - registered rising-edge detector for one debounced button level
module calc_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_prev;

  // Resetting to 1 keeps a button held through reset from reporting an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b1;
    else      r_prev <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - button-to-command sequencer and digit scan for the BCD adder
// Optional sum watchdog enabled by defining CALC_CTRL_WDOG_EN.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DFLT,
  parameter int SCAN_DIV    = 50000,
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  calc_ctrl_if.slave bus
);

  localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic w_push_e, w_guar_e, w_fin_e;
  logic w_push, w_guar, w_fin, w_digit_ok, w_wdog_hit;

  calc_edge u_edge_push (.clk(clk), .rst(rst), .i_lvl(bus.push),      .o_rise(w_push_e));
  calc_edge u_edge_guar (.clk(clk), .rst(rst), .i_lvl(bus.guardar),   .o_rise(w_guar_e));
  calc_edge u_edge_fin  (.clk(clk), .rst(rst), .i_lvl(bus.finalizar), .o_rise(w_fin_e));

  assign w_fin      = w_fin_e;
  assign w_guar     = w_guar_e & ~w_fin_e;
  assign w_push     = w_push_e & ~w_guar_e & ~w_fin_e;
  assign w_digit_ok = (bus.entrada <= 4'(BCD_MAX));

  calc_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_have_saved, w_have_saved_nxt;
  logic             r_show_result, w_show_result_nxt;
  logic [3:0]       r_dig_value, w_dig_value_nxt;
  logic             r_dig_shift, w_dig_shift_nxt;
  logic             r_op_save, w_op_save_nxt;
  logic             r_sum_start, w_sum_start_nxt;
  logic             r_clr_entry, w_clr_entry_nxt;
  logic             r_err, w_err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_have_saved  <= 1'b0;
      r_show_result <= 1'b0;
      r_dig_value   <= 4'd0;
      r_dig_shift   <= 1'b0;
      r_op_save     <= 1'b0;
      r_sum_start   <= 1'b0;
      r_clr_entry   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_have_saved  <= w_have_saved_nxt;
      r_show_result <= w_show_result_nxt;
      r_dig_value   <= w_dig_value_nxt;
      r_dig_shift   <= w_dig_shift_nxt;
      r_op_save     <= w_op_save_nxt;
      r_sum_start   <= w_sum_start_nxt;
      r_clr_entry   <= w_clr_entry_nxt;
      r_err         <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_have_saved_nxt  = r_have_saved;
    w_show_result_nxt = r_show_result;
    w_dig_value_nxt   = r_dig_value;
    w_dig_shift_nxt   = 1'b0;
    w_op_save_nxt     = 1'b0;
    w_sum_start_nxt   = 1'b0;
    w_clr_entry_nxt   = 1'b0;
    w_err_nxt         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          if (w_digit_ok) begin
            w_dig_shift_nxt = 1'b1;
            w_dig_value_nxt = bus.entrada;
            w_count_nxt     = CNT_W'(1);
            w_state_nxt     = ENTRY;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ENTRY: begin
        if (w_fin) begin
          if (r_have_saved) begin
            w_sum_start_nxt = 1'b1;
            w_state_nxt     = SUMMING;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_guar) begin
          w_op_save_nxt    = 1'b1;
          w_count_nxt      = '0;
          w_have_saved_nxt = 1'b1;
        end else if (w_push) begin
          if (w_digit_ok && (r_count < CNT_W'(NUM_DIGITS))) begin
            w_dig_shift_nxt = 1'b1;
            w_dig_value_nxt = bus.entrada;
            w_count_nxt     = r_count + CNT_W'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      SUMMING: begin
        if (bus.sum_done) begin
          w_show_result_nxt = 1'b1;
          w_state_nxt       = RESULT;
        end else if (w_wdog_hit) begin
          w_err_nxt         = 1'b1;
          w_clr_entry_nxt   = 1'b1;
          w_have_saved_nxt  = 1'b0;
          w_show_result_nxt = 1'b0;
          w_state_nxt       = IDLE;
        end
      end
      RESULT: begin
        if (w_push) begin
          if (w_digit_ok) begin
            w_clr_entry_nxt   = 1'b1;
            w_have_saved_nxt  = 1'b0;
            w_show_result_nxt = 1'b0;
            w_dig_value_nxt   = bus.entrada;
            w_state_nxt       = RELOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RELOAD: begin
        // Replays the digit that ended the result view as the first new digit.
        w_dig_shift_nxt = 1'b1;
        w_count_nxt     = CNT_W'(1);
        w_state_nxt     = ENTRY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef CALC_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_wdog <= '0;
    else if (r_state == SUMMING) r_wdog <= r_wdog + WD_W'(1);
    else                        r_wdog <= '0;
  end

  assign w_wdog_hit = (r_state == SUMMING) && (r_wdog == WD_W'(WDOG_CYCLES - 1));
`else
  assign w_wdog_hit = 1'b0;
`endif

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [SEL_W-1:0]  r_digit_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= (r_digit_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_digit_sel + SEL_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign bus.dig_shift   = r_dig_shift;
  assign bus.dig_value   = r_dig_value;
  assign bus.op_save     = r_op_save;
  assign bus.sum_start   = r_sum_start;
  assign bus.clr_entry   = r_clr_entry;
  assign bus.show_result = r_show_result;
  assign bus.err         = r_err;
  assign bus.digit_sel   = r_digit_sel;
  assign bus.an          = ~(NUM_DIGITS'(1) << r_digit_sel);

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - scoreboard bench for calc_ctrl (NUM_DIGITS=4, SCAN_DIV=4, WDOG_CYCLES=16)
module tb_calc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic m_sr = 1'b0;
  logic [3:0] m_dv = 4'd0;
  logic prev_sr = 1'b0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  calc_ctrl_if #(.NUM_DIGITS(4)) bus ();

  calc_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .WDOG_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected event = {dig_shift, op_save, sum_start, clr_entry, err, show_result, dig_value}
  task automatic ev(input bit ds, input bit os, input bit ss, input bit ce, input bit er);
    sb_q.push_back({ds, os, ss, ce, er, m_sr, m_dv});
  endtask

  always @(negedge clk) begin
    logic [9:0] obs;
    logic       pulse;
    obs   = {bus.dig_shift, bus.op_save, bus.sum_start, bus.clr_entry, bus.err,
             bus.show_result, bus.dig_value};
    pulse = bus.dig_shift | bus.op_save | bus.sum_start | bus.clr_entry | bus.err;
    if (rst && (pulse || (bus.show_result != prev_sr))) begin
      if (sb_q.size() == 0) chk("sb_unexpected", sb_q.size(), 1);
      else                  chk("sb_event", obs, sb_q.pop_front());
    end
    prev_sr = bus.show_result;
  end

  task automatic press(input bit p, input bit g, input bit f, input logic [3:0] d);
    @(posedge clk); #1;
    bus.push = p; bus.guardar = g; bus.finalizar = f; bus.entrada = d;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.guardar = 1'b0; bus.finalizar = 1'b0;
    @(posedge clk);
  endtask

  task automatic pulse_sum_done();
    @(posedge clk); #1 bus.sum_done = 1'b1;
    @(posedge clk); #1 bus.sum_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dig_shift", bus.dig_shift, 0);
    chk("rst_op_save", bus.op_save, 0);
    chk("rst_sum_start", bus.sum_start, 0);
    chk("rst_clr_entry", bus.clr_entry, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_show_result", bus.show_result, 0);
    chk("rst_dig_value", bus.dig_value, 0);
    chk("rst_digit_sel", bus.digit_sel, 0);
    chk("rst_an", bus.an, 4'b1110);
    m_sr = 1'b0;
    m_dv = 4'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.push = 1'b0; bus.guardar = 1'b0; bus.finalizar = 1'b0;
    bus.entrada = 4'd0; bus.sum_done = 1'b0;

    // Scan: digit_sel advances every SCAN_DIV cycles starting SCAN_DIV after release
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      logic [1:0] es;
      logic [3:0] ea;
      @(negedge clk);
      es = 2'((i / 4) % 4);
      ea = ~(4'b0001 << es);
      chk("scan_digit_sel", bus.digit_sel, es);
      chk("scan_an", bus.an, ea);
    end

    // First digit: one-cycle latency from edge to dig_shift
    m_dv = 4'd3; ev(1, 0, 0, 0, 0);
    @(posedge clk); #1 bus.push = 1'b1; bus.entrada = 4'd3;
    @(negedge clk); chk("lat_before_edge", bus.dig_shift, 0);
    @(posedge clk); #1 bus.push = 1'b0;
    @(negedge clk); chk("lat_dig_shift", bus.dig_shift, 1);
    chk("lat_dig_value", bus.dig_value, 3);
    @(negedge clk); chk("lat_one_cycle", bus.dig_shift, 0);
    idle(2);

    // Digit overflow: four shifts, fifth push errors
    do_reset();
    for (int d = 1; d <= 4; d++) begin
      m_dv = 4'(d); ev(1, 0, 0, 0, 0);
      press(1, 0, 0, 4'(d));
    end
    ev(0, 0, 0, 0, 1);
    press(1, 0, 0, 4'd5);

    // finalizar without saved operand errors; then full save/sum sequence
    do_reset();
    m_dv = 4'd1; ev(1, 0, 0, 0, 0); press(1, 0, 0, 4'd1);
    ev(0, 0, 0, 0, 1); press(0, 0, 1, 4'd0);
    m_dv = 4'd2; ev(1, 0, 0, 0, 0); press(1, 0, 0, 4'd2);
    ev(0, 1, 0, 0, 0); press(0, 1, 0, 4'd0);
    m_dv = 4'd3; ev(1, 0, 0, 0, 0); press(1, 0, 0, 4'd3);
    m_dv = 4'd4; ev(1, 0, 0, 0, 0); press(1, 0, 0, 4'd4);
    ev(0, 0, 1, 0, 0); press(0, 0, 1, 4'd0);
    press(1, 0, 0, 4'd9);
    idle(1);
    m_sr = 1'b1; ev(0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.sum_done = 1'b1;
    @(negedge clk); chk("sum_sr_before", bus.show_result, 0);
    @(posedge clk); #1 bus.sum_done = 1'b0;
    @(negedge clk); chk("sum_sr_after", bus.show_result, 1);

    // RESULT: guardar ignored, push 7 clears then reloads the digit
    press(0, 1, 0, 4'd0);
    m_sr = 1'b0; m_dv = 4'd7; ev(0, 0, 0, 1, 0); ev(1, 0, 0, 0, 0);
    press(1, 0, 0, 4'd7);

    // Invalid digit, guardar beats push, count restarts from 0
    ev(0, 0, 0, 0, 1); press(1, 0, 0, 4'hA);
    ev(0, 1, 0, 0, 0); press(1, 1, 0, 4'd5);
    for (int d = 1; d <= 4; d++) begin
      m_dv = 4'(d); ev(1, 0, 0, 0, 0);
      press(1, 0, 0, 4'(d));
    end
    ev(0, 0, 0, 0, 1); press(1, 0, 0, 4'd6);
    ev(0, 0, 1, 0, 0); press(0, 0, 1, 4'd0);

    // SUMMING with no sum_done: watchdog timeout or indefinite wait
`ifdef CALC_CTRL_WDOG_EN
    ev(0, 0, 0, 1, 1);
    idle(22);
    pulse_sum_done();
`else
    idle(40);
    m_sr = 1'b1; ev(0, 0, 0, 0, 0);
    pulse_sum_done();
`endif
    idle(3);

    // Reset mid-state with push held across release: no edge afterwards
    bus.push = 1'b1; bus.entrada = 4'd2;
    do_reset();
    idle(3);
    bus.push = 1'b0;
    idle(3);
    @(negedge clk);
    chk("sb_final_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the 4-digit BCD adder datapath. It turns debounced push/guardar/finalizar button levels into one-cycle command strobes for the entry, save and sum stages, and tracks digit count and operand state. It drives the operand/result display select and the free-running 7-segment digit scan. It sits between the board buttons and the Push_datos / Guardado_datos / Suma_datos / display chain.

## Interface
- NUM_DIGITS, 4: digits per operand and per display.
- SCAN_DIV, 50000: clk cycles per display digit slot (≥2).
- WDOG_CYCLES, 255: sum watchdog limit in cycles (used only with CALC_CTRL_WDOG_EN).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  debounced, clk-synchronous level; rising edge = enter digit.
- guardar  in  1  debounced level; rising edge = save current operand.
- finalizar  in  1  debounced level; rising edge = start sum.
- entrada  in  4  BCD digit sampled with push edge.
- sum_done  in  1  one-cycle pulse from adder, result valid.
- dig_shift  out  1  pulse: shift dig_value into entry register.
- dig_value  out  4  digit registered at the accepted push.
- op_save  out  1  pulse: copy entry to saved operand and clear entry.
- sum_start  out  1  pulse: start addition.
- clr_entry  out  1  pulse: clear entry and saved operand.
- show_result  out  1  level: 1 = display result, 0 = display entry.
- digit_sel  out  $clog2(NUM_DIGITS)  digit currently scanned.
- an  out  NUM_DIGITS  active-low one-hot anode, an[digit_sel]=0.
- err  out  1  one-cycle error pulse.

## Operation
- Reset values: all pulses 0, dig_value 0, show_result 0, digit_sel 0, an = all ones except an[0]=0, state IDLE, count 0, have_saved 0.
- Edge detect per button: an edge at cycle N exists when the input is high at N and was low at N-1.
- Same-cycle edge priority: finalizar > guardar > push. Lower-priority edges in that cycle are dropped.
- A push with entrada > 9 never shifts. It produces an err pulse and leaves the state unchanged.
- IDLE: valid push → dig_shift, count=1, go to ENTRY. guardar/finalizar are ignored.
- ENTRY:
  - Valid push with count<NUM_DIGITS → dig_shift, count++.
  - Push with count==NUM_DIGITS → err, no shift.
  - guardar → op_save, count=0, have_saved=1, stay in ENTRY. If have_saved is already 1, the previous saved value is overwritten.
  - finalizar with have_saved=1 → sum_start, go to SUMMING. With have_saved=0 → err.
- SUMMING: all buttons ignored. sum_done → show_result=1, go to RESULT.
- RESULT:
  - Valid push → clr_entry, have_saved=0, show_result=0, go to RELOAD.
  - guardar/finalizar are ignored.
- RELOAD (one cycle): dig_shift with the held digit, count=1, go to ENTRY.
- sum_done outside SUMMING is ignored.
- Scan: a counter wraps at SCAN_DIV-1. At each wrap, digit_sel increments modulo NUM_DIGITS. Scanning runs in every state.

## Timing
- Edge at cycle N → the command pulse is registered and visible at N+1, lasting exactly one cycle. dig_value updates at N+1 and holds until the next accepted digit.
- err is also registered at N+1.
- sum_done at cycle M → show_result=1 at M+1.
- RESULT push edge at N → clr_entry at N+1, dig_shift at N+2.
- The first digit_sel advance occurs SCAN_DIV cycles after reset release. Each subsequent advance follows every SCAN_DIV cycles.
- Asserting rst at any time, including mid-SUMMING or mid-RELOAD, forces reset values immediately. A held button level does not create an edge after reset release; the edge registers reset to 1.

## Configuration
- CALC_CTRL_WDOG_EN defined:
  - A counter runs while in SUMMING.
  - Reaching WDOG_CYCLES cycles without sum_done → err and clr_entry pulses, have_saved=0, show_result=0, go to IDLE.
  - sum_done on the same cycle as the timeout wins.
- Undefined: SUMMING waits indefinitely, and the counter is not synthesized.

## Structure
- Package calc_pkg:
  - State enum typedef: IDLE, ENTRY, SUMMING, RESULT, RELOAD.
  - BCD_MAX=9 and default NUM_DIGITS.
- One sub-module, calc_edge: registered rising-edge detector with async active-low reset and reset value 1. It is instantiated once per button.

## Test plan
- Reset, SCAN_DIV=4, push with entrada=3 → dig_shift=1, dig_value=3 one cycle after the edge. digit_sel steps 0→1→2→3→0 every 4 cycles.
- Pushes 1,2,3,4,5 → four dig_shift pulses. The fifth push gives an err pulse with no shift.
- Enter 12, guardar, enter 34, finalizar, sum_done 3 cycles later → op_save and sum_start pulses; show_result=1 on the cycle after sum_done.
- push with entrada=4'hA → err pulse, no dig_shift. Simultaneous guardar+push in ENTRY → op_save only, count=0.
- In RESULT, push with entrada=7 → clr_entry, then dig_shift with dig_value=7 the next cycle; show_result=0.
- With CALC_CTRL_WDOG_EN and WDOG_CYCLES=16: finalizar, no sum_done for 16 cycles → err and clr_entry pulses, back in IDLE. Repeat without the macro → remains in SUMMING.
